// File: rtl/axi_lite_ptgen_master.sv
// AXI4-Lite master that writes an incrementing pattern to consecutive words,
// reads every word back and flags any response or data mismatch on ERROR.
module axi_lite_ptgen_master #(
  parameter int          C_M_AXI_ADDR_WIDTH   = 32,
  parameter int          C_M_AXI_DATA_WIDTH   = 32,
  parameter logic [31:0] C_M_TARGET_BASE_ADDR = 32'h4000_0000,
  parameter int          C_M_TRANSACTIONS_NUM = 4,
  parameter logic [31:0] C_PATTERN_SEED       = 32'hA5A5_0000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            INIT_AXI_TXN,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(C_M_TRANSACTIONS_NUM - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = C_M_AXI_ADDR_WIDTH'(C_M_TARGET_BASE_ADDR);
  localparam logic [C_M_AXI_DATA_WIDTH-1:0] SEED      = C_M_AXI_DATA_WIDTH'(C_PATTERN_SEED);

  state_t                          state_reg;
  logic                            init_q_reg;
  logic [7:0]                      idx_reg;
  logic                            aw_done_reg;
  logic                            w_done_reg;
  logic                            awvalid_reg;
  logic                            wvalid_reg;
  logic                            bready_reg;
  logic                            arvalid_reg;
  logic                            rready_reg;
  logic                            txn_done_reg;
  logic                            error_reg;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_reg;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_reg;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_reg;

  logic                            start;
  logic                            aw_ok;
  logic                            w_ok;
  logic [C_M_AXI_DATA_WIDTH-1:0]   exp_rdata;

  assign start     = INIT_AXI_TXN & ~init_q_reg;
  // A channel counts as done if it handshook earlier or is handshaking on this edge.
  assign aw_ok     = aw_done_reg | (awvalid_reg & M_AXI_AWREADY);
  assign w_ok      = w_done_reg  | (wvalid_reg  & M_AXI_WREADY);
  assign exp_rdata = SEED + C_M_AXI_DATA_WIDTH'(idx_reg);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg    <= IDLE;
      init_q_reg   <= 1'b0;
      idx_reg      <= '0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      awvalid_reg  <= 1'b0;
      wvalid_reg   <= 1'b0;
      bready_reg   <= 1'b0;
      arvalid_reg  <= 1'b0;
      rready_reg   <= 1'b0;
      txn_done_reg <= 1'b0;
      error_reg    <= 1'b0;
      awaddr_reg   <= '0;
      araddr_reg   <= '0;
      wdata_reg    <= '0;
    end else begin
      init_q_reg <= INIT_AXI_TXN;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg    <= WRITE;
            txn_done_reg <= 1'b0;
            error_reg    <= 1'b0;
            idx_reg      <= '0;
            awaddr_reg   <= BASE_ADDR;
            wdata_reg    <= SEED;
            awvalid_reg  <= 1'b1;
            wvalid_reg   <= 1'b1;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
          end
        end
        WRITE: begin
          if (awvalid_reg && M_AXI_AWREADY) begin
            awvalid_reg <= 1'b0;
            aw_done_reg <= 1'b1;
          end
          if (wvalid_reg && M_AXI_WREADY) begin
            wvalid_reg <= 1'b0;
            w_done_reg <= 1'b1;
          end
          if (bready_reg) begin
            if (M_AXI_BVALID) begin
              bready_reg  <= 1'b0;
              aw_done_reg <= 1'b0;
              w_done_reg  <= 1'b0;
              if (M_AXI_BRESP != 2'b00) error_reg <= 1'b1;
              if (idx_reg == LAST_IDX) begin
                state_reg   <= READ;
                idx_reg     <= '0;
                araddr_reg  <= BASE_ADDR;
                arvalid_reg <= 1'b1;
              end else begin
                idx_reg     <= idx_reg + 8'd1;
                awaddr_reg  <= awaddr_reg + C_M_AXI_ADDR_WIDTH'(4);
                wdata_reg   <= wdata_reg + C_M_AXI_DATA_WIDTH'(1);
                awvalid_reg <= 1'b1;
                wvalid_reg  <= 1'b1;
              end
            end
          end else if (aw_ok && w_ok) begin
            bready_reg <= 1'b1;
          end
        end
        READ: begin
          if (arvalid_reg && M_AXI_ARREADY) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
          end
          if (rready_reg && M_AXI_RVALID) begin
            rready_reg <= 1'b0;
            if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != exp_rdata) error_reg <= 1'b1;
            if (idx_reg == LAST_IDX) begin
              state_reg    <= DONE;
              txn_done_reg <= 1'b1;
            end else begin
              idx_reg     <= idx_reg + 8'd1;
              araddr_reg  <= araddr_reg + C_M_AXI_ADDR_WIDTH'(4);
              arvalid_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign TXN_DONE      = txn_done_reg;
  assign ERROR         = error_reg;
  assign M_AXI_AWADDR  = awaddr_reg;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_reg;
  assign M_AXI_WDATA   = wdata_reg;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_reg;
  assign M_AXI_BREADY  = bready_reg;
  assign M_AXI_ARADDR  = araddr_reg;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_reg;
  assign M_AXI_RREADY  = rready_reg;

endmodule

// File: tb/tb_axi_lite_ptgen_master.sv
// Bench for axi_lite_ptgen_master: small AXI-Lite slave memory model, write/read
// scoreboards, and directed runs covering stalls, error responses and reset.
module tb_axi_lite_ptgen_master;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] SEED = 32'hA5A5_0000;
  localparam int          N    = 4;

  logic        clk = 1'b0;
  logic        areset;
  logic        init;
  logic        txn_done, error;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_ptgen_master dut (
    .ACLK(clk), .ARESET(areset), .INIT_AXI_TXN(init),
    .TXN_DONE(txn_done), .ERROR(error),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave controls driven by the stimulus
  int  aw_delay      = 0;
  int  bresp_err_idx = -1;
  bit  corrupt_en    = 1'b0;

  logic [63:0] wr_exp_q[$];
  logic [31:0] rd_exp_q[$];

  // Slave memory model
  logic [31:0] mem [0:15];
  int          aw_wait_cnt;
  logic        aw_have, w_have;
  logic [31:0] aw_addr_q, w_data_q;
  logic [31:0] wa, wd, woff, roff;
  logic [63:0] wexp;
  logic [31:0] rexp;
  logic        aw_hs, w_hs;

  assign awready = (aw_wait_cnt >= aw_delay);
  assign wready  = 1'b1;
  assign arready = 1'b1;
  assign rresp   = 2'b00;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

  always @(posedge clk) begin
    if (areset) begin
      aw_have     <= 1'b0;
      w_have      <= 1'b0;
      bvalid      <= 1'b0;
      bresp       <= 2'b00;
      rvalid      <= 1'b0;
      rdata       <= '0;
      aw_wait_cnt <= 0;
      wr_exp_q.delete();
      rd_exp_q.delete();
    end else begin
      if (awvalid && !awready) aw_wait_cnt <= aw_wait_cnt + 1;
      else                     aw_wait_cnt <= 0;
      if (bvalid && bready) bvalid <= 1'b0;
      if ((aw_have || aw_hs) && (w_have || w_hs) && !bvalid) begin
        wa   = aw_hs ? awaddr : aw_addr_q;
        wd   = w_hs ? wdata : w_data_q;
        woff = wa - BASE;
        mem[woff[5:2]] <= wd;
        bvalid  <= 1'b1;
        bresp   <= (int'(woff[31:2]) == bresp_err_idx) ? 2'b10 : 2'b00;
        aw_have <= 1'b0;
        w_have  <= 1'b0;
        $display("[%0t] write addr=0x%08h data=0x%08h", $time, wa, wd);
        chk("wr_sb_pending", 64'(wr_exp_q.size() != 0), 64'd1);
        if (wr_exp_q.size() != 0) begin
          wexp = wr_exp_q.pop_front();
          chk("wr_addr", 64'(wa), 64'(wexp[63:32]));
          chk("wr_data", 64'(wd), 64'(wexp[31:0]));
        end
      end else begin
        if (aw_hs) begin aw_have <= 1'b1; aw_addr_q <= awaddr; end
        if (w_hs)  begin w_have  <= 1'b1; w_data_q  <= wdata;  end
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        roff = araddr - BASE;
        rvalid <= 1'b1;
        rdata  <= mem[roff[5:2]];
        $display("[%0t] read  addr=0x%08h data=0x%08h", $time, araddr, mem[roff[5:2]]);
        chk("rd_sb_pending", 64'(rd_exp_q.size() != 0), 64'd1);
        if (rd_exp_q.size() != 0) begin
          rexp = rd_exp_q.pop_front();
          chk("rd_addr", 64'(araddr), 64'(rexp));
        end
      end
      if (corrupt_en && arvalid) mem[1] <= 32'h0;
    end
  end

  // Handshake statistics (cumulative; stimulus works on deltas)
  int aw_hs_cnt = 0, ar_hs_cnt = 0, r_hs_cnt = 0, bready_early = 0;
  int aw_run = 0, w_run = 0, aw_len_last = 0, w_len_last = 0;

  always @(posedge clk) begin
    if (areset) begin
      aw_run <= 0;
      w_run  <= 0;
    end else begin
      if (awvalid) begin
        if (awready) begin
          aw_hs_cnt   <= aw_hs_cnt + 1;
          aw_len_last <= aw_run + 1;
          aw_run      <= 0;
        end else aw_run <= aw_run + 1;
      end
      if (wvalid) begin
        if (wready) begin
          w_len_last <= w_run + 1;
          w_run      <= 0;
        end else w_run <= w_run + 1;
      end
      if (arvalid && arready) ar_hs_cnt <= ar_hs_cnt + 1;
      if (rvalid && rready) r_hs_cnt <= r_hs_cnt + 1;
      if (bready && awvalid) bready_early <= bready_early + 1;
    end
  end

  task automatic push_exp();
    for (int i = 0; i < N; i++) begin
      wr_exp_q.push_back({BASE + 32'(4 * i), SEED + 32'(i)});
      rd_exp_q.push_back(BASE + 32'(4 * i));
    end
  endtask

  task automatic start_run();
    push_exp();
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!txn_done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("done_reached", 64'(txn_done), 64'd1);
  endtask

  task automatic wait_r(input int target);
    int n = 0;
    while (r_hs_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("r_hs_reached", 64'(r_hs_cnt >= target), 64'd1);
  endtask

  int lat, aw0, ar0, r0, be0;

  initial begin
    areset = 1'b1;
    init   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({awvalid, wvalid, bready, arvalid, rready, txn_done, error}), 64'd0);
    chk("reset_addrdata", 64'({awaddr, wdata}) | 64'(araddr), 64'd0);
    chk("const_prot_strb", 64'({awprot, arprot, wstrb}), 64'({3'b000, 3'b000, 4'hF}));
    areset = 1'b0;
    @(negedge clk);

    // Zero-wait slave
    aw0 = aw_hs_cnt;
    start_run();
    chk("zw_clear_on_start", 64'({txn_done, error}), 64'd0);
    wait_done(lat);
    chk("zw_latency", 64'(lat), 64'(4 * N + 1));
    chk("zw_error", 64'(error), 64'd0);
    chk("zw_aw_count", 64'(aw_hs_cnt - aw0), 64'(N));
    chk("zw_sb_empty", 64'(wr_exp_q.size() + rd_exp_q.size()), 64'd0);

    // AWREADY delayed 3 cycles
    aw_delay = 3;
    aw0 = aw_hs_cnt;
    be0 = bready_early;
    start_run();
    while (aw_hs_cnt == aw0 && txn_done == 1'b0) @(negedge clk);
    chk("dly_aw_len", 64'(aw_len_last), 64'd4);
    chk("dly_w_len", 64'(w_len_last), 64'd1);
    wait_done(lat);
    chk("dly_bready_early", 64'(bready_early - be0), 64'd0);
    chk("dly_error", 64'(error), 64'd0);
    chk("dly_sb_empty", 64'(wr_exp_q.size() + rd_exp_q.size()), 64'd0);
    aw_delay = 0;

    // SLVERR on write 2
    bresp_err_idx = 2;
    ar0 = ar_hs_cnt;
    start_run();
    wait_done(lat);
    chk("bresp_error", 64'(error), 64'd1);
    chk("bresp_reads", 64'(ar_hs_cnt - ar0), 64'(N));
    chk("bresp_sb_empty", 64'(wr_exp_q.size() + rd_exp_q.size()), 64'd0);
    bresp_err_idx = -1;

    // Word 1 corrupted before the read phase
    corrupt_en = 1'b1;
    r0 = r_hs_cnt;
    start_run();
    chk("corr_error_cleared", 64'(error), 64'd0);
    wait_r(r0 + 1);
    chk("corr_error_word0", 64'(error), 64'd0);
    wait_r(r0 + 2);
    chk("corr_error_word1", 64'(error), 64'd1);
    wait_done(lat);
    chk("corr_error_done", 64'(error), 64'd1);
    corrupt_en = 1'b0;

    // INIT held high for 100 cycles, with an error so the restart must clear it
    bresp_err_idx = 0;
    aw0 = aw_hs_cnt;
    push_exp();
    @(negedge clk); init = 1'b1;
    @(negedge clk);
    chk("hold_error_cleared", 64'({txn_done, error}), 64'd0);
    repeat (99) @(negedge clk);
    chk("hold_aw_count", 64'(aw_hs_cnt - aw0), 64'(N));
    chk("hold_done_err", 64'({txn_done, error}), 64'b11);
    bresp_err_idx = -1;
    init = 1'b0;
    @(negedge clk);
    start_run();
    chk("restart_clear", 64'({txn_done, error}), 64'd0);
    wait_done(lat);
    chk("restart_error", 64'(error), 64'd0);
    chk("restart_aw_count", 64'(aw_hs_cnt - aw0), 64'(2 * N));

    // Reset during READ
    r0 = r_hs_cnt;
    start_run();
    wait_r(r0 + 1);
    areset = 1'b1;
    @(negedge clk);
    chk("midrst_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, txn_done, error}), 64'd0);
    chk("midrst_addr", 64'(araddr), 64'd0);
    chk("midrst_awdata", 64'({awaddr, wdata}), 64'd0);
    areset = 1'b0;
    @(negedge clk);
    start_run();
    wait_done(lat);
    chk("postrst_latency", 64'(lat), 64'(4 * N + 1));
    chk("postrst_error", 64'(error), 64'd0);
    chk("postrst_sb_empty", 64'(wr_exp_q.size() + rd_exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "global timeout");
  end

endmodule
